// File: rtl/child_collector_pkg.sv
// Shared defaults, the source-tag type and the wrap-around index helper
// used by the child response collector.
package child_collector_pkg;

    localparam int NUM_CHILDREN_DEFAULT = 5;
    localparam int DATA_W_DEFAULT       = 16;
    localparam int CNT_W_DEFAULT        = 8;
    localparam int SRC_W_DEFAULT        = $clog2(NUM_CHILDREN_DEFAULT);

    // Widest index the collector supports (up to 16 children).
    localparam int IDX_W_MAX = 4;

    typedef logic [SRC_W_DEFAULT-1:0] src_idx_t;

    // Increment an index modulo n.
    function automatic logic [IDX_W_MAX-1:0] next_idx(
        input logic [IDX_W_MAX-1:0] idx,
        input int                   n
    );
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + IDX_W_MAX'(1);
    endfunction

endpackage

// File: rtl/child_response_collector_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr,
// wrapping modulo N, gets a one-hot grant while enable is high.
module rr_arbiter #(
    parameter  int N  = 5,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] cand_idx [N];
    logic [N-1:0]  cand_req;

    // Candidate gi is the child sitting gi positions after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum          = {1'b0, ptr} + (IW+1)'(gi);
            assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (enable && cand_req[k]) begin
                grant_idx   = cand_idx[k];
                grant_valid = 1'b1;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/child_response_collector.sv
// Merges the response streams of NUM_CHILDREN children into one registered
// upstream stream tagged with the source child, with saturating beat counters.
module child_response_collector
    import child_collector_pkg::*;
#(
    parameter  int NUM_CHILDREN = NUM_CHILDREN_DEFAULT,
    parameter  int DATA_W       = DATA_W_DEFAULT,
    parameter  int CNT_W        = CNT_W_DEFAULT,
    localparam int SRC_W        = $clog2(NUM_CHILDREN)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CHILDREN-1:0]         child_valid,
    input  logic [NUM_CHILDREN*DATA_W-1:0]  child_data,
    output logic [NUM_CHILDREN-1:0]         child_ready,
    output logic                            up_valid,
    output logic [DATA_W-1:0]               up_data,
    output logic [SRC_W-1:0]                up_src,
    input  logic                            up_ready,
    output logic [NUM_CHILDREN*CNT_W-1:0]   beat_cnt
);

    logic                    can_load;
    logic                    accept;
    logic [NUM_CHILDREN-1:0] grant;
    logic [SRC_W-1:0]        grant_idx;
    logic [IDX_W_MAX-1:0]    ptr_next_wide;
    logic [DATA_W-1:0]       child_data_arr [NUM_CHILDREN];

    logic                    up_valid_q, up_valid_d;
    logic [DATA_W-1:0]       up_data_q,  up_data_d;
    logic [SRC_W-1:0]        up_src_q,   up_src_d;
    logic [SRC_W-1:0]        rr_ptr_q,   rr_ptr_d;

    // The single output register may take a new beat when empty or draining.
    assign can_load = !up_valid_q || up_ready;

    rr_arbiter #(
        .N (NUM_CHILDREN)
    ) u_arb (
        .req         (child_valid),
        .ptr         (rr_ptr_q),
        .enable      (can_load && !rst),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (accept)
    );

    assign child_ready   = grant;
    assign ptr_next_wide = next_idx(IDX_W_MAX'(grant_idx), NUM_CHILDREN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHILDREN; gi++) begin : g_child
            logic [CNT_W-1:0] cnt_q, cnt_d;

            assign child_data_arr[gi] = child_data[gi*DATA_W +: DATA_W];

            always_comb begin
                cnt_d = cnt_q;
                if (grant[gi] && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign beat_cnt[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    // A new accept overwrites the register even while the old beat drains.
    always_comb begin
        up_valid_d = up_valid_q;
        up_data_d  = up_data_q;
        up_src_d   = up_src_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            up_valid_d = 1'b1;
            up_data_d  = child_data_arr[grant_idx];
            up_src_d   = grant_idx;
            rr_ptr_d   = SRC_W'(ptr_next_wide);
        end else if (up_valid_q && up_ready) begin
            up_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_valid_q <= 1'b0;
            up_data_q  <= '0;
            up_src_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            up_valid_q <= up_valid_d;
            up_data_q  <= up_data_d;
            up_src_q   <= up_src_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign up_valid = up_valid_q;
    assign up_data  = up_data_q;
    assign up_src   = up_src_q;

endmodule

// File: tb/tb_child_response_collector.sv
// Randomized and directed bench for child_response_collector with a
// queue-based scoreboard fed by a behavioural round-robin model.
module tb_child_response_collector;
    import child_collector_pkg::*;

    localparam int NC = 5;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam int SW = $clog2(NC);

    logic              clk;
    logic              rst;
    logic [NC-1:0]     child_valid;
    logic [NC*DW-1:0]  child_data;
    logic [NC-1:0]     child_ready;
    logic              up_valid;
    logic [DW-1:0]     up_data;
    logic [SW-1:0]     up_src;
    logic              up_ready;
    logic [NC*CW-1:0]  beat_cnt;

    child_response_collector #(
        .NUM_CHILDREN (NC),
        .DATA_W       (DW),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .up_valid    (up_valid),
        .up_data     (up_data),
        .up_src      (up_src),
        .up_ready    (up_ready),
        .beat_cnt    (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [15:0] data;
    } beat_t;

    beat_t        sb[$];
    int           tests_run = 0;
    int           fails     = 0;
    int           m_ptr     = 0;
    bit           m_full    = 0;
    int           m_cnt [NC];
    logic [NC-1:0] pending = '0;
    logic [DW-1:0] nd [NC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grant rule, occupancy and counters straight from the rules.
    always @(negedge clk) begin
        if (rst) begin
            check("ready_in_reset", 64'(child_ready), 64'd0);
            m_ptr   = 0;
            m_full  = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            sb.delete();
            pending = '0;
        end else begin
            logic [NC*CW-1:0] exp_bc;
            logic [NC-1:0]    exp_ready;
            int               g;
            bit               can;
            for (int i = 0; i < NC; i++) exp_bc[i*CW +: CW] = CW'(m_cnt[i]);
            check("up_valid", 64'(up_valid), 64'(m_full));
            check("beat_cnt", 64'(beat_cnt), 64'(exp_bc));
            can = !m_full || up_ready;
            g   = -1;
            if (can) begin
                for (int k = 0; k < NC; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NC;
                    if (g < 0 && child_valid[idx]) g = idx;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("child_ready", 64'(child_ready), 64'(exp_ready));
            if (g >= 0) begin
                beat_t b;
                b.src  = g;
                b.data = child_data[g*DW +: DW];
                sb.push_back(b);
                m_ptr  = (g + 1) % NC;
                if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
                m_full = 1;
            end else if (m_full && up_ready) begin
                m_full = 0;
            end
            pending = child_valid & ~child_ready;
        end
    end

    // Monitor: compares every delivered beat and checks stall stability.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_src;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(up_valid), 64'd1);
                check("stall_data", 64'(up_data), 64'(prev_data));
                check("stall_src", 64'(up_src), 64'(prev_src));
            end
            if (up_valid && up_ready) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL sb_empty: got beat src=%0d data=%h expected none", up_src, up_data);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    $display("[TB] beat src=%0d data=%h (exp src=%0d data=%h)", up_src, up_data, e.src, e.data);
                    check("up_src", 64'(up_src), 64'(e.src));
                    check("up_data", 64'(up_data), 64'(e.data));
                end
            end
            prev_stall = up_valid && !up_ready;
            prev_data  = up_data;
            prev_src   = up_src;
        end
    end

    task automatic drive(input logic [NC-1:0] vmask, input logic rdy, input logic r);
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (!pending[i]) child_data[i*DW +: DW] = nd[i];
        end
        child_valid = vmask;
        up_ready    = rdy;
        rst         = r;
    endtask

    task automatic rand_nd();
        for (int i = 0; i < NC; i++) nd[i] = DW'($urandom);
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        child_valid = '0;
        child_data  = '0;
        up_ready    = 1'b0;
        rand_nd();

        // Reset with all children requesting.
        for (int c = 0; c < 3; c++) begin
            drive('1, 1'b1, 1'b1);
            @(negedge clk);
            check("rst_ready", 64'(child_ready), 64'd0);
            check("rst_up_valid", 64'(up_valid), 64'd0);
            check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        end

        // Round robin over all children, full throughput.
        for (int k = 0; k < 10; k++) begin
            rand_nd();
            drive('1, 1'b1, 1'b0);
            @(negedge clk);
            if (k == 0) check("first_grant", 64'(child_ready), 64'd1);
            if (k >= 1) check("rr_src", 64'(up_src), 64'((k - 1) % NC));
        end
        drive('0, 1'b1, 1'b0);
        @(negedge clk);
        check("rr_cnt", 64'(beat_cnt), 64'({NC{8'd2}}));

        // Backpressure hold, then load during the drain cycle.
        do_reset();
        nd[2] = 16'hA5A5;
        drive(5'b00100, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            rand_nd();
            drive('1, 1'b0, 1'b0);
            @(negedge clk);
            check("bp_data", 64'(up_data), 64'h0000_A5A5);
            check("bp_src", 64'(up_src), 64'd2);
            check("bp_ready", 64'(child_ready), 64'd0);
        end
        drive('1, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_release_grant", 64'(child_ready), 64'b01000);
        drive('0, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_release_src", 64'(up_src), 64'd3);

        // Sparse request after pointer reaches 4.
        do_reset();
        drive(5'b01000, 1'b1, 1'b0);
        drive(5'b00010, 1'b1, 1'b0);
        @(negedge clk);
        check("sparse_grant", 64'(child_ready), 64'b00010);
        drive('1, 1'b1, 1'b0);
        @(negedge clk);
        check("sparse_next", 64'(child_ready), 64'b00100);

        // Wrap from pointer 4 to child 0.
        do_reset();
        drive(5'b10000, 1'b1, 1'b0);
        drive(5'b00001, 1'b1, 1'b0);
        @(negedge clk);
        check("wrap_grant", 64'(child_ready), 64'b00001);

        // Counter saturation.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            nd[0] = DW'(k);
            drive(5'b00001, 1'b1, 1'b0);
        end
        drive('0, 1'b1, 1'b0);
        @(negedge clk);
        check("sat_cnt", 64'(beat_cnt), 64'd255);

        // Reset while a beat is held under backpressure.
        do_reset();
        drive(5'b00001, 1'b1, 1'b0);
        drive('0, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_held", 64'(up_valid), 64'd1);
        drive('0, 1'b0, 1'b1);
        drive('0, 1'b1, 1'b0);
        @(negedge clk);
        check("mid_up_valid", 64'(up_valid), 64'd0);
        check("mid_cnt", 64'(beat_cnt), 64'd0);
        drive('1, 1'b1, 1'b0);
        @(negedge clk);
        check("mid_ptr", 64'(child_ready), 64'd1);

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rand_nd();
            drive(NC'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end
        drive('0, 1'b1, 1'b0);
        drive('0, 1'b1, 1'b0);
        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/child_response_collector.md
Name: child_response_collector

Overview:
- Fan-in counterpart to the root-level fan-out instantiation of child modules.
- Collects valid/ready response beats from NUM_CHILDREN child instances and merges them into one upstream stream, tagged with the source child index.
- Uses round-robin arbitration and a single registered output stage.
- Keeps a saturating per-child beat counter for hierarchy-level debug visibility.

Parameters:
- NUM_CHILDREN, 5, number of child response ports (2..16).
- DATA_W, 16, payload width per beat.
- CNT_W, 8, width of each per-child accepted-beat counter.
- SRC_W, $clog2(NUM_CHILDREN), width of the source index tag (derived, not overridable).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- child_valid  in  NUM_CHILDREN  per-child beat valid.
- child_data  in  NUM_CHILDREN*DATA_W  per-child payload; child i occupies bits [i*DATA_W +: DATA_W].
- child_ready  out  NUM_CHILDREN  per-child accept; combinational.
- up_valid  out  1  upstream beat valid (registered).
- up_data  out  DATA_W  upstream payload (registered).
- up_src  out  SRC_W  index of the child that produced up_data (registered).
- up_ready  in  1  upstream accept.
- beat_cnt  out  NUM_CHILDREN*CNT_W  per-child accepted-beat counters, saturating.

Behaviour:
- Reset (rst=1 at a clock edge): up_valid=0, up_data=0, up_src=0, all beat_cnt=0, rr_ptr=0.
  - child_ready=0 while rst=1 (gated combinationally).
  - Reset mid-transfer discards any held beat; no replay.
- Output stage is one register. can_load = !up_valid | up_ready.
- Grant:
  - Search child_valid starting at rr_ptr, wrapping modulo NUM_CHILDREN.
  - The first asserted child gets grant g. Grant is one-hot or zero.
- child_ready[i] = can_load & grant[i] & !rst. At most one child_ready is high per cycle.
- Accept: child_valid[g] & child_ready[g] at an edge. Then:
  - up_data<=child_data[g], up_src<=g, up_valid<=1.
  - rr_ptr<=(g+1) mod NUM_CHILDREN.
  - beat_cnt[g]++ unless it equals all-ones (saturates, no wrap).
- Upstream handshake: when up_valid & up_ready and no new accept occurs, up_valid<=0.
  - Simultaneous upstream drain and child accept: the new beat replaces the old one in the same cycle. Full throughput is 1 beat/cycle.
- Stall: up_valid & !up_ready ⇒ all child_ready=0. up_data and up_src hold stable.
- Latency: a child beat accepted at edge N appears on up_* after edge N (1 cycle).
- Fairness:
  - rr_ptr advances only on accept.
  - With all children continuously valid and up_ready=1, grants cycle 0,1,2,3,4,0,...
  - A valid child waits at most NUM_CHILDREN-1 accepted beats.
- Wrap: rr_ptr=NUM_CHILDREN-1 with child 0 valid ⇒ grant 0.
- No children valid ⇒ grant=0. rr_ptr is unchanged.
- Protocol assumption on children: child_data stable while child_valid & !child_ready. The block does not check this.

Decomposition:
- Package child_collector_pkg:
  - NUM_CHILDREN_DEFAULT, DATA_W_DEFAULT, CNT_W_DEFAULT.
  - typedef src_idx_t (logic [SRC_W-1:0]).
  - function next_idx(idx) implementing the modulo-NUM_CHILDREN increment.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N], ptr, enable. Outputs grant[N] (one-hot) and grant_idx.
  - Purely combinational.
  - The top level owns rr_ptr, the output register and the counters.

Test Plan:
- Reset: drive all child_valid=1 while rst=1 ⇒ child_ready=0, up_valid=0, beat_cnt all 0. Release rst ⇒ first grant goes to child 0 and up_src=0 one cycle later.
- Round-robin, all children valid, up_ready=1, 10 cycles ⇒ up_src sequence 0,1,2,3,4,0,1,2,3,4. Each beat_cnt=2. up_data matches the driven per-child values.
- Backpressure:
  - Child 2 beat 0xA5A5 accepted, then up_ready=0 for 4 cycles ⇒ up_valid=1, up_data=0xA5A5, up_src=2 held stable. All child_ready=0.
  - Then up_ready=1 ⇒ next beat loads in the same cycle.
- Sparse/wrap: rr_ptr=4 after child 3 is granted, only child 1 valid ⇒ grant 1. rr_ptr becomes 2. No grant to idle children.
- Saturation: CNT_W=8, 300 beats from child 0 only ⇒ beat_cnt[0]=255, others 0.
- Mid-operation reset: assert rst while up_valid=1 and up_ready=0 ⇒ next cycle up_valid=0, counters 0, rr_ptr=0. The held beat is never delivered.
